stream_mux_rr: RTL



---
 rtl/stream_mux_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/stream_mux_rr.sv | 121 ++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping
// from NUM_CH-1 back to 0. The caller must keep ptr below NUM_CH.
module rr_arbiter #(
  parameter int NUM_CH = 8,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;
  logic [SEL_W:0]      offset;
  logic [SEL_W:0]      idx_sum;
  logic                found;

  // Rotate so that the channel at ptr lands in bit 0, then pick the lowest set bit.
  assign req_dbl = {req, req};
  assign req_rot = NUM_CH'(req_dbl >> ptr);

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found && req_rot[j]) begin
        found  = 1'b1;
        offset = (SEL_W+1)'(j);
      end
    end
  end

  always_comb begin
    idx_sum = {1'b0, ptr} + offset;
    if (idx_sum >= NUM_CH_W) begin
      idx_sum = idx_sum - NUM_CH_W;
    end
  end

  assign grant_idx = idx_sum[SEL_W-1:0];
  assign grant     = found ? (NUM_CH'(1) << grant_idx) : '0;

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with explicit-select or round-robin
// selection and a single registered output stage. STREAM_MUX_CNT_EN adds a transfer counter.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_ch
`ifdef STREAM_MUX_CNT_EN
  ,
  output logic [XFER_CNT_W-1:0]    xfer_cnt,
  output logic                     cnt_ovf
`endif
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] rr_grant;
  logic [SEL_W-1:0]  rr_idx;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic              sel_hit;
  logic              load;
  logic              any_grant;
  logic [SEL_W-1:0]  rr_ptr_next;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  assign load = !out_valid || out_ready;

  // An out-of-range sel matches no channel, so no grant is issued.
  always_comb begin
    sel_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_hit = in_valid[i];
      end
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (mode == MODE_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
    end else if (sel_hit) begin
      grant     = NUM_CH'(1) << sel;
      grant_idx = sel;
    end
  end

  assign any_grant = |grant;
  assign in_ready  = (rst || !load) ? '0 : grant;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        grant_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rr_ptr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (any_grant) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_idx;
        // Explicit-select transfers leave the round-robin position untouched.
        if (mode == MODE_RR) begin
          rr_ptr <= rr_ptr_next;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef STREAM_MUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + XFER_CNT_W'(1);
      if (xfer_cnt == '1) begin
        cnt_ovf <= 1'b1;
      end
    end
  end
`endif

endmodule
